// File: rtl/ex_div_if.sv
// ex_div_if: request/response bundle for the iterative divider.
// Signals:
//   start_i, abort_i                 issue / flush controls
//   op_i, dividend_i, divisor_i      funct3 and operands of the request
//   reg_waddr_i                      destination register of the request
//   result_o, ready_o                result and its one-cycle valid pulse
//   busy_o                           divider not idle
//   reg_waddr_o                      destination register of the result
// The master modport belongs to the requester; the slave modport to ex_div.
interface ex_div_if;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned AREG_W = 5;
  localparam int unsigned OP_W   = 3;

  logic              start_i;
  logic              abort_i;
  logic [OP_W-1:0]   op_i;
  logic [XLEN-1:0]   dividend_i;
  logic [XLEN-1:0]   divisor_i;
  logic [AREG_W-1:0] reg_waddr_i;
  logic [XLEN-1:0]   result_o;
  logic              ready_o;
  logic              busy_o;
  logic [AREG_W-1:0] reg_waddr_o;

  modport master (
    output start_i, abort_i, op_i, dividend_i, divisor_i, reg_waddr_i,
    input  result_o, ready_o, busy_o, reg_waddr_o
  );

  modport slave (
    input  start_i, abort_i, op_i, dividend_i, divisor_i, reg_waddr_i,
    output result_o, ready_o, busy_o, reg_waddr_o
  );
endinterface

// File: rtl/ex_div.sv
// ex_div: 32-bit RISC-V DIV/DIVU/REM/REMU unit, restoring division, one
// quotient bit per cycle (IDLE -> START -> CALC x32 -> END).
// Ports:
//   clk_i    clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   bus      ex_div_if.slave (start/abort/op/operands/waddr in;
//            result/ready/busy/waddr out, all registered)
// Configuration:
//   DIV_FAST_ZERO_EN  when defined, a zero divisor skips CALC and goes from
//                     START straight to END (same results, shorter latency).
module ex_div (
  input  logic     clk_i,
  input  logic     rst_n_i,
  ex_div_if.slave  bus
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned AREG_W = 5;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned LAST_ITER = XLEN - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_CALC  = 2'd2,
    S_END   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [AREG_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]   a_orig_q, a_orig_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   div_q, div_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div_zero_q, div_zero_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [AREG_W-1:0] waddr_out_q, waddr_out_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  // op decode: bit1 selects remainder, bit0 unsigned; signed only for M-ext ops
  logic op_rem_c, op_signed_c;
  assign op_rem_c    = op_q[1];
  assign op_signed_c = op_q[2] & ~op_q[0];

  // Sign of operands as held in quo_q/div_q during START
  logic a_neg_c, b_neg_c;
  assign a_neg_c = op_signed_c & quo_q[XLEN-1];
  assign b_neg_c = op_signed_c & div_q[XLEN-1];

  // One restoring step: shift next dividend bit in, subtract if it fits
  logic [XLEN:0]   trial_c;
  logic [XLEN:0]   diff_c;
  logic            fits_c;
  logic [XLEN-1:0] step_quo_c;
  logic [XLEN-1:0] step_rem_c;
  assign trial_c    = {rem_q, quo_q[XLEN-1]};
  assign diff_c     = trial_c - {1'b0, div_q};
  assign fits_c     = (trial_c >= {1'b0, div_q});
  assign step_quo_c = {quo_q[XLEN-2:0], fits_c};
  assign step_rem_c = fits_c ? diff_c[XLEN-1:0] : trial_c[XLEN-1:0];

  // Final result after the last step, including divide-by-zero override
  logic [XLEN-1:0] zero_res_c;
  logic [XLEN-1:0] quo_fin_c;
  logic [XLEN-1:0] rem_fin_c;
  logic [XLEN-1:0] fin_res_c;
  assign zero_res_c = op_rem_c ? a_orig_q : '1;
  assign quo_fin_c  = neg_quo_q ? (XLEN'(0) - step_quo_c) : step_quo_c;
  assign rem_fin_c  = neg_rem_q ? (XLEN'(0) - step_rem_c) : step_rem_c;
  assign fin_res_c  = div_zero_q ? zero_res_c : (op_rem_c ? rem_fin_c : quo_fin_c);

  // Next-state and register updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    waddr_d     = waddr_q;
    a_orig_d    = a_orig_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    div_d       = div_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    div_zero_d  = div_zero_q;
    result_d    = result_q;
    waddr_out_d = waddr_out_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.abort_i) begin
          state_d  = S_START;
          op_d     = bus.op_i;
          waddr_d  = bus.reg_waddr_i;
          a_orig_d = bus.dividend_i;
          quo_d    = bus.dividend_i;
          div_d    = bus.divisor_i;
        end
      end

      S_START: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
        end else begin
          // Work on magnitudes; signs are restored at the end
          quo_d      = a_neg_c ? (XLEN'(0) - quo_q) : quo_q;
          div_d      = b_neg_c ? (XLEN'(0) - div_q) : div_q;
          neg_quo_d  = a_neg_c ^ b_neg_c;
          neg_rem_d  = a_neg_c;
          div_zero_d = (div_q == '0);
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = S_CALC;
`ifdef DIV_FAST_ZERO_EN
          if (div_q == '0) begin
            state_d     = S_END;
            result_d    = zero_res_c;
            waddr_out_d = waddr_q;
          end
`endif
        end
      end

      S_CALC: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
        end else begin
          quo_d = step_quo_c;
          rem_d = step_rem_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LAST_ITER)) begin
            state_d     = S_END;
            result_d    = fin_res_c;
            waddr_out_d = waddr_q;
          end
        end
      end

      S_END: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_END);
    busy_d  = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      waddr_q     <= '0;
      a_orig_q    <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      result_q    <= '0;
      waddr_out_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      waddr_q     <= waddr_d;
      a_orig_q    <= a_orig_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      div_zero_q  <= div_zero_d;
      result_q    <= result_d;
      waddr_out_q <= waddr_out_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.result_o    = result_q;
  assign bus.ready_o     = ready_q;
  assign bus.busy_o      = busy_q;
  assign bus.reg_waddr_o = waddr_out_q;
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: scoreboard bench for ex_div. The driver pushes the expected
// result, destination and ready cycle of every accepted request; a monitor
// pops and compares on every ready_o pulse. Expected values come from plain
// signed/unsigned arithmetic with the RISC-V corner cases.
module tb_ex_div;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ex_div_if bus();

  ex_div dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wa;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_wa  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_model(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    int sa;
    int sbv;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    sa  = int'(a);
    sbv = int'(b);
    return op[1] ? 32'(sa % sbv) : 32'(sa / sbv);
  endfunction

  function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_FAST_ZERO_EN
    return (b == 32'd0) ? 2 : 34;
`else
    if (b == 32'd0) return 34;
    return 34;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n && bus.ready_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got result 0x%08h expected no pulse", bus.result_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, bus.result_o, e.res);
        check({e.name, "_waddr"}, 32'(bus.reg_waddr_o), 32'(e.wa));
        check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Present a request in the current (IDLE) cycle; returns one cycle later
  task automatic issue(input string name, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    exp_t e;
    bus.start_i     = 1'b1;
    bus.op_i        = op;
    bus.dividend_i  = a;
    bus.divisor_i   = b;
    bus.reg_waddr_i = wa;
    e.res  = ref_model(op, a, b);
    e.wa   = wa;
    e.cyc  = cyc + exp_latency(b);
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    bus.start_i = 1'b0;
    check({name, "_busy"}, 32'(bus.busy_o), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
    end
  endtask

  task automatic run(input string name, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    issue(name, op, a, b, wa);
    wait_idle(name);
    last_res = ref_model(op, a, b);
    last_wa  = wa;
  endtask

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  initial begin
    bus.start_i     = 1'b0;
    bus.abort_i     = 1'b0;
    bus.op_i        = '0;
    bus.dividend_i  = '0;
    bus.divisor_i   = '0;
    bus.reg_waddr_i = '0;

    #1 rst_n = 1'b0;
    #2;
    check("rst_result", bus.result_o, 32'd0);
    check("rst_ready", 32'(bus.ready_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_waddr", 32'(bus.reg_waddr_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd1);
    run("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd2);
    run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3);
    run("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5);
    run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    run("div_5_0", OP_DIV, 32'd5, 32'd0, 5'd7);
    run("rem_5_0", OP_REM, 32'd5, 32'd0, 5'd8);
    run("divu_0", OP_DIVU, 32'hDEAD_BEEF, 32'd0, 5'd10);
    run("remu_0", OP_REMU, 32'hDEAD_BEEF, 32'd0, 5'd11);

    // Abort during CALC iteration 10
    issue("abort_op", OP_DIV, 32'd1000, 32'd3, 5'd9);
    repeat (10) @(negedge clk);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    void'(sb.pop_back());
    check("abort_busy", 32'(bus.busy_o), 32'd0);
    check("abort_ready", 32'(bus.ready_o), 32'd0);
    check("abort_result_kept", bus.result_o, last_res);
    check("abort_waddr_kept", 32'(bus.reg_waddr_o), 32'(last_wa));
    run("after_abort", OP_DIVU, 32'd1000, 32'd3, 5'd12);

    // Abort together with start in IDLE must not accept
    bus.abort_i = 1'b1;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    bus.start_i = 1'b0;
    check("abort_start_idle_busy", 32'(bus.busy_o), 32'd0);

    // Reset mid-CALC
    issue("reset_op", OP_REMU, 32'd12345, 32'd77, 5'd13);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("midrst_result", bus.result_o, 32'd0);
    check("midrst_ready", 32'(bus.ready_o), 32'd0);
    check("midrst_busy", 32'(bus.busy_o), 32'd0);
    check("midrst_waddr", 32'(bus.reg_waddr_o), 32'd0);
    last_res = '0;
    last_wa  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // start held high while busy is ignored
    issue("held_start", OP_DIVU, 32'd999, 32'd10, 5'd14);
    bus.start_i = 1'b1;
    repeat (20) @(negedge clk);
    bus.start_i = 1'b0;
    wait_idle("held_start");
    last_res = ref_model(OP_DIVU, 32'd999, 32'd10);
    last_wa  = 5'd14;
    // back-to-back: next start in the cycle right after END
    run("b2b", OP_REM, 32'hFFFF_FF00, 32'd7, 5'd15);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = {1'b1, 2'($urandom_range(0, 3))};
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      run("rand", op, a, b, 5'($urandom));
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
